// File: rtl/dma_bus_grant_ctrl.sv
// dma_bus_grant_ctrl: CPU-side BR/BG bus arbitration and DMA job control.
// Launches a DMA job on a dma_start_int rising edge, grants the data-memory
// bus to the DMA on BR once the CPU is quiet, and closes the job on dma_end_int.
// Optional feature macro: DMA_WATCHDOG_EN (aborts a job stuck for WDT_CYCLES).
module dma_bus_grant_ctrl #(
    parameter int unsigned          WORD_SIZE     = 16,
    parameter logic [WORD_SIZE-1:0] DMA_BASE_ADDR = WORD_SIZE'(16'h01F4),
    parameter logic [WORD_SIZE-1:0] DMA_LENGTH    = WORD_SIZE'(16'd12),
    parameter int unsigned          WDT_CYCLES    = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dma_start_int,
    input  logic                 dma_end_int,
    input  logic                 BR,
    input  logic                 d_bus_busy,
    output logic                 cmd,
    output logic [WORD_SIZE-1:0] cmd_addr,
    output logic [WORD_SIZE-1:0] cmd_len,
    output logic                 BG,
    output logic                 cpu_bus_hold,
    output logic                 dma_busy,
    output logic [WORD_SIZE-1:0] xfer_count,
    output logic                 start_overflow,
    output logic                 dma_error
);

    localparam int unsigned WDT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_BR,
        S_HOLD,
        S_GRANT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 start_prev_q;
    logic                 pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic                 err_q, err_d;
    logic [WDT_W-1:0]     wdt_q, wdt_d;
    logic                 cmd_q, cmd_d;
    logic [WORD_SIZE-1:0] cmd_addr_q, cmd_addr_d;
    logic [WORD_SIZE-1:0] cmd_len_q, cmd_len_d;
    logic                 bg_q, bg_d;
    logic                 hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic [WORD_SIZE-1:0] count_q, count_d;
    logic                 start_evt_c;

    // One start event per rising edge of the device interrupt.
    assign start_evt_c = dma_start_int & ~start_prev_q;

    // Next-state, pending-slot, watchdog and registered-output computation.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        wdt_d      = wdt_q;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_CMD;
                    pending_d = start_evt_c;
                end else if (start_evt_c) begin
                    state_d = S_CMD;
                end
            end
            S_CMD:     state_d = S_WAIT_BR;
            S_WAIT_BR: begin
                if (dma_end_int)  state_d = S_DONE;
                else if (BR)      state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!BR)              state_d = S_WAIT_BR;
                else if (!d_bus_busy) state_d = S_GRANT;
            end
            S_GRANT: begin
                // End of transfer takes priority over BR dropping.
                if (dma_end_int) state_d = S_DONE;
                else if (!BR)    state_d = S_WAIT_BR;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // A start while a job runs parks in the single pending slot.
        if ((state_q != S_IDLE) && start_evt_c) begin
            if (pending_q) overflow_d = 1'b1;
            else           pending_d  = 1'b1;
        end

`ifdef DMA_WATCHDOG_EN
        if (state_q == S_CMD) begin
            wdt_d = '0;
        end else if ((state_q == S_WAIT_BR) || (state_q == S_HOLD) || (state_q == S_GRANT)) begin
            if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                wdt_d   = '0;
            end else begin
                wdt_d = wdt_q + WDT_W'(1);
            end
        end
`endif

        cmd_d      = (state_d == S_CMD);
        cmd_addr_d = cmd_d ? DMA_BASE_ADDR : '0;
        cmd_len_d  = cmd_d ? DMA_LENGTH : '0;
        bg_d       = (state_d == S_GRANT);
        hold_d     = (state_d == S_HOLD) || (state_d == S_GRANT);
        busy_d     = (state_d != S_IDLE);
        count_d    = count_q + WORD_SIZE'(state_d == S_DONE);
    end

`ifndef DMA_WATCHDOG_EN
    logic unused_wdt;
    assign unused_wdt = ^{32'(WDT_CYCLES), wdt_d};
`endif

    // All state and outputs; reset drops grant and hold immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
            wdt_q        <= '0;
            cmd_q        <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            bg_q         <= 1'b0;
            hold_q       <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= dma_start_int;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            err_q        <= err_d;
            wdt_q        <= wdt_d;
            cmd_q        <= cmd_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_len_q    <= cmd_len_d;
            bg_q         <= bg_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
        end
    end

    assign cmd            = cmd_q;
    assign cmd_addr       = cmd_addr_q;
    assign cmd_len        = cmd_len_q;
    assign BG             = bg_q;
    assign cpu_bus_hold   = hold_q;
    assign dma_busy       = busy_q;
    assign xfer_count     = count_q;
    assign start_overflow = overflow_q;
    assign dma_error      = err_q;

endmodule

// File: tb/tb_dma_bus_grant_ctrl.sv
// Directed bench for dma_bus_grant_ctrl with hand-computed expectations.
module tb_dma_bus_grant_ctrl;

    logic        clk;
    logic        reset;
    logic        dma_start_int;
    logic        dma_end_int;
    logic        br;
    logic        d_bus_busy;
    logic        cmd;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        bg;
    logic        cpu_bus_hold;
    logic        dma_busy;
    logic [15:0] xfer_count;
    logic        start_overflow;
    logic        dma_error;

    int errors = 0;
    int checks = 0;

    dma_bus_grant_ctrl #(
        .WORD_SIZE(16),
        .DMA_BASE_ADDR(16'h01F4),
        .DMA_LENGTH(16'd12),
        .WDT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dma_start_int(dma_start_int),
        .dma_end_int(dma_end_int),
        .BR(br),
        .d_bus_busy(d_bus_busy),
        .cmd(cmd),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .BG(bg),
        .cpu_bus_hold(cpu_bus_hold),
        .dma_busy(dma_busy),
        .xfer_count(xfer_count),
        .start_overflow(start_overflow),
        .dma_error(dma_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        dma_start_int = 1'b0;
        dma_end_int   = 1'b0;
        br            = 1'b0;
        d_bus_busy    = 1'b0;

        // 1: reset values, then quiet idle
        tick(2);
        chk1("rst_cmd", cmd, 1'b0);
        chk16("rst_addr", cmd_addr, 16'h0000);
        chk16("rst_len", cmd_len, 16'h0000);
        chk1("rst_bg", bg, 1'b0);
        chk1("rst_hold", cpu_bus_hold, 1'b0);
        chk1("rst_busy", dma_busy, 1'b0);
        chk16("rst_count", xfer_count, 16'h0000);
        chk1("rst_ovf", start_overflow, 1'b0);
        chk1("rst_err", dma_error, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk1("idle_cmd", cmd, 1'b0);
        end

        // 2: start edge, cmd pulse, three BR bursts, end during grant
        dma_start_int = 1'b1;
        tick(1);
        chk1("t2_cmd", cmd, 1'b1);
        chk16("t2_addr", cmd_addr, 16'h01F4);
        chk16("t2_len", cmd_len, 16'd12);
        chk1("t2_busy", dma_busy, 1'b1);
        tick(1);
        chk1("t2_cmd_one", cmd, 1'b0);
        chk16("t2_addr_off", cmd_addr, 16'h0000);
        br = 1'b1;
        tick(1);
        chk1("t2_hold", cpu_bus_hold, 1'b1);
        chk1("t2_bg_not_yet", bg, 1'b0);
        tick(1);
        chk1("t2_bg1", bg, 1'b1);
        br = 1'b0;
        tick(1);
        chk1("t2_bg1_drop", bg, 1'b0);
        chk1("t2_hold_drop", cpu_bus_hold, 1'b0);
        br = 1'b1;
        tick(2);
        chk1("t2_bg2", bg, 1'b1);
        br = 1'b0;
        tick(1);
        chk1("t2_bg2_drop", bg, 1'b0);
        br = 1'b1;
        tick(2);
        chk1("t2_bg3", bg, 1'b1);
        br = 1'b0;
        dma_end_int = 1'b1;
        tick(1);
        dma_end_int = 1'b0;
        chk1("t2_done_bg", bg, 1'b0);
        chk1("t2_done_busy", dma_busy, 1'b1);
        chk16("t2_done_count", xfer_count, 16'd1);
        tick(1);
        chk1("t2_idle_busy", dma_busy, 1'b0);
        chk16("t2_count", xfer_count, 16'd1);

        // 3: CPU busy delays the grant
        dma_start_int = 1'b0;
        tick(1);
        dma_start_int = 1'b1;
        tick(1);
        chk1("t3_cmd", cmd, 1'b1);
        dma_start_int = 1'b0;
        tick(1);
        br = 1'b1;
        d_bus_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk1("t3_hold", cpu_bus_hold, 1'b1);
            chk1("t3_bg_blocked", bg, 1'b0);
        end
        d_bus_busy = 1'b0;
        tick(1);
        chk1("t3_bg", bg, 1'b1);
        br = 1'b0;
        dma_end_int = 1'b1;
        tick(1);
        dma_end_int = 1'b0;
        tick(1);
        chk16("t3_count", xfer_count, 16'd2);

        // 4: pending slot and overflow (fresh counters)
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk16("t4_count_rst", xfer_count, 16'd0);
        dma_start_int = 1'b1;
        tick(1);
        chk1("t4_cmd1", cmd, 1'b1);
        dma_start_int = 1'b0;
        tick(1);
        dma_start_int = 1'b1;
        tick(1);
        dma_start_int = 1'b0;
        chk1("t4_no_ovf", start_overflow, 1'b0);
        tick(1);
        dma_start_int = 1'b1;
        tick(1);
        dma_start_int = 1'b0;
        chk1("t4_ovf", start_overflow, 1'b1);
        dma_end_int = 1'b1;
        tick(1);
        dma_end_int = 1'b0;
        chk16("t4_count1", xfer_count, 16'd1);
        tick(1);
        chk1("t4_idle_cmd", cmd, 1'b0);
        tick(1);
        chk1("t4_cmd2", cmd, 1'b1);
        tick(1);
        dma_end_int = 1'b1;
        tick(1);
        dma_end_int = 1'b0;
        tick(1);
        chk16("t4_count2", xfer_count, 16'd2);
        chk1("t4_busy", dma_busy, 1'b0);
        chk1("t4_ovf_sticky", start_overflow, 1'b1);
        tick(3);
        chk1("t4_no_third", cmd, 1'b0);

        // 5: asynchronous reset during grant
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        dma_start_int = 1'b1;
        tick(1);
        dma_start_int = 1'b0;
        tick(1);
        br = 1'b1;
        tick(2);
        chk1("t5_bg", bg, 1'b1);
        reset = 1'b1;
        #1;
        chk1("t5_bg_async", bg, 1'b0);
        chk1("t5_hold_async", cpu_bus_hold, 1'b0);
        chk1("t5_busy_async", dma_busy, 1'b0);
        chk16("t5_count", xfer_count, 16'd0);
        br = 1'b0;
        tick(1);
        reset = 1'b0;

        // 6: stuck grant with BR held and no end interrupt
        dma_start_int = 1'b1;
        tick(1);
        dma_start_int = 1'b0;
        tick(1);
        br = 1'b1;
        tick(2);
        chk1("t6_bg", bg, 1'b1);
        tick(40);
`ifdef DMA_WATCHDOG_EN
        chk1("t6_bg_abort", bg, 1'b0);
        chk1("t6_err", dma_error, 1'b1);
        chk1("t6_busy", dma_busy, 1'b0);
`else
        chk1("t6_bg_held", bg, 1'b1);
        chk1("t6_err", dma_error, 1'b0);
        chk1("t6_busy", dma_busy, 1'b1);
`endif
        chk16("t6_count", xfer_count, 16'd0);
        br = 1'b0;
        dma_end_int = 1'b1;
        tick(1);
        dma_end_int = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
